// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
//   Round-robin arbiter that shares one synchronous single-port data RAM
//   among NCORES cores. Each granted request runs a fixed
//   IDLE -> ISSUE -> READ -> ACK sequence. Read data comes back on a shared bus.
//
// Ports
//   clock      system clock, rising edge
//   rst        synchronous reset, active-high
//   req        per-core request, held until ack
//   we         per-core write enable (qualified by req)
//   addr       per-core address, core i at [i*AW +: AW]
//   wdata      per-core write data, core i at [i*DW +: DW]
//   gnt        one-hot grant (registered)
//   ack        one-cycle completion pulse (registered)
//   rdata      shared read data, valid while ack is high
//   busy       high whenever the sequencer is not IDLE
//   mem_addr   RAM address (registered)
//   mem_wdata  RAM write data (registered)
//   mem_we     RAM write strobe, only in ISSUE (registered)
//   mem_rdata  RAM read data, valid the cycle after the address
module shared_mem_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int IW     = 2
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    ack,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_we,
    input  logic [DW-1:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_READ,
        S_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                wr_q, wr_d;      // winner's write flag, needed after mem_we drops
    logic [NCORES-1:0]   gnt_q, gnt_d;
    logic [NCORES-1:0]   ack_q, ack_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [AW-1:0]       maddr_q, maddr_d;
    logic [DW-1:0]       mwdata_q, mwdata_d;
    logic                mwe_q, mwe_d;

    // Round-robin search starting at ptr_q, wrapping modulo NCORES
    logic                found;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            cand = IW'((32'(ptr_q) + k) % NCORES);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwe_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d  = S_ISSUE;
                    idx_d    = win;
                    wr_d     = we[win];
                    gnt_d    = NCORES'(1) << win;
                    maddr_d  = addr[win*AW +: AW];
                    mwdata_d = wdata[win*DW +: DW];
                    mwe_d    = we[win];
                end
            end
            S_ISSUE: begin
                state_d = S_READ;
            end
            S_READ: begin
                state_d = S_ACK;
                if (!wr_q) begin
                    rdata_d = mem_rdata;
                end
                ack_d = NCORES'(1) << idx_q;
            end
            S_ACK: begin
                state_d = S_IDLE;
                ptr_d   = IW'((32'(idx_q) + 1) % NCORES);
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            gnt_q    <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwe_q    <= mwe_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign mem_we    = mwe_q;

endmodule
